// File: rtl/isp_frame_loader_if.sv
// Loader bus: UART receive side (EN, RXDATA, RX_FLAG_P), program memory write
// port (WRITE, WRADDR, WRDATA), CPU reset and loader status.
// The master drives the receive side; the slave is the loader itself.
interface isp_frame_loader_if;
  logic        EN;
  logic [7:0]  RXDATA;
  logic        RX_FLAG_P;
  logic        CORE_RESETn;
  logic        WRITE;
  logic [15:0] WRADDR;
  logic [31:0] WRDATA;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  modport master (
    output EN, RXDATA, RX_FLAG_P,
    input  CORE_RESETn, WRITE, WRADDR, WRDATA, BUSY, DONE, ERR
  );

  modport slave (
    input  EN, RXDATA, RX_FLAG_P,
    output CORE_RESETn, WRITE, WRADDR, WRDATA, BUSY, DONE, ERR
  );
endinterface

// File: rtl/isp_frame_loader.sv
// In-system-programming frame loader.
// Parses 0xA5, LEN_H, LEN_L, 4*N little-endian data bytes [, checksum] from
// the UART byte stream, writes 32-bit words to program memory and keeps the
// CPU in reset while the loader owns the memory port.
// Optional feature macro: ISP_CSUM_EN (adds a trailing modulo-256 checksum
// byte; without it DONE follows the last word write).
module isp_frame_loader #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned MAX_WORDS   = 1024,
  parameter logic [23:0] TIMEOUT_CYC = 24'd500000
) (
  input logic               HCLK,
  input logic               HRESETn,
  isp_frame_loader_if.slave bus
);

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [16:0] MAX_LEN   = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LENH  = 3'd1,
    ST_LENL  = 3'd2,
    ST_DATA  = 3'd3,
`ifdef ISP_CSUM_EN
    ST_CSUM  = 3'd4,
`endif
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  // States in which a frame is in progress (BUSY, timeout counter running).
  function automatic logic is_active(input state_t s);
    case (s)
      ST_LENH, ST_LENL, ST_DATA: is_active = 1'b1;
`ifdef ISP_CSUM_EN
      ST_CSUM:                   is_active = 1'b1;
`endif
      default:                   is_active = 1'b0;
    endcase
  endfunction

`ifdef ISP_CSUM_EN
  // Modulo-256 running sum of data bytes.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    csum_add = acc + b;
  endfunction
`endif

  state_t      state_r, state_nx_s;
  logic        sync_s, lenh_s, len_load_s, data_byte_s, word_full_s;
  logic        fin_ok_s, fin_err_s, abort_s, tmo_hit_s, len_bad_s;
  logic        active_s, busy_nx_s;
  logic [15:0] len_s;

  logic [7:0]  len_h_r;
  logic [15:0] word_cnt_r;
  logic [1:0]  byte_cnt_r;
  logic [23:0] word_buf_r;
  logic [31:0] wrdata_r;
  logic        write_r;
  logic [15:0] wraddr_r;
  logic        busy_r, done_r, err_r, core_resetn_r;
  logic [23:0] tmo_cnt_r;
`ifdef ISP_CSUM_EN
  logic [7:0]  csum_r;
`endif

  assign len_s     = {len_h_r, bus.RXDATA};
  assign len_bad_s = (len_s == 16'd0) || ({1'b0, len_s} > MAX_LEN);
  assign tmo_hit_s = (tmo_cnt_r >= TIMEOUT_CYC);
  // Dropping EN or a stalled sender ends the frame without further writes.
  assign abort_s   = !bus.EN || tmo_hit_s;
  assign active_s  = is_active(state_r);
  assign busy_nx_s = is_active(state_nx_s);

  // FSM state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    state_nx_s  = state_r;
    sync_s      = 1'b0;
    lenh_s      = 1'b0;
    len_load_s  = 1'b0;
    data_byte_s = 1'b0;
    word_full_s = 1'b0;
    fin_ok_s    = 1'b0;
    fin_err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.EN && bus.RX_FLAG_P && (bus.RXDATA == SYNC_BYTE)) begin
          state_nx_s = ST_LENH;
          sync_s     = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LENH: begin
        if (abort_s) begin
          state_nx_s = ST_ERROR;
          fin_err_s  = 1'b1;
        end else if (bus.RX_FLAG_P) begin
          state_nx_s = ST_LENL;
          lenh_s     = 1'b1;
        end else begin
          state_nx_s = ST_LENH;
        end
      end
      ST_LENL: begin
        if (abort_s) begin
          state_nx_s = ST_ERROR;
          fin_err_s  = 1'b1;
        end else if (bus.RX_FLAG_P) begin
          if (len_bad_s) begin
            state_nx_s = ST_ERROR;
            fin_err_s  = 1'b1;
          end else begin
            state_nx_s = ST_DATA;
            len_load_s = 1'b1;
          end
        end else begin
          state_nx_s = ST_LENL;
        end
      end
      ST_DATA: begin
        if (abort_s) begin
          state_nx_s = ST_ERROR;
          fin_err_s  = 1'b1;
        end else if (write_r && (word_cnt_r == 16'd1)) begin
`ifdef ISP_CSUM_EN
          state_nx_s = ST_CSUM;
`else
          state_nx_s = ST_DONE;
          fin_ok_s   = 1'b1;
`endif
        end else if (bus.RX_FLAG_P) begin
          state_nx_s  = ST_DATA;
          data_byte_s = 1'b1;
          word_full_s = (byte_cnt_r == 2'd3);
        end else begin
          state_nx_s = ST_DATA;
        end
      end
`ifdef ISP_CSUM_EN
      ST_CSUM: begin
        if (abort_s) begin
          state_nx_s = ST_ERROR;
          fin_err_s  = 1'b1;
        end else if (bus.RX_FLAG_P) begin
          if (bus.RXDATA == csum_r) begin
            state_nx_s = ST_DONE;
            fin_ok_s   = 1'b1;
          end else begin
            state_nx_s = ST_ERROR;
            fin_err_s  = 1'b1;
          end
        end else begin
          state_nx_s = ST_CSUM;
        end
      end
`endif
      ST_DONE:  state_nx_s = ST_IDLE;
      ST_ERROR: state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Word assembly and the one-cycle memory write; address advances after the write.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      word_buf_r <= 24'd0;
      wrdata_r   <= 32'd0;
      write_r    <= 1'b0;
      wraddr_r   <= BASE_ADDR;
      byte_cnt_r <= 2'd0;
    end else begin
      write_r <= word_full_s;
      if (word_full_s) begin
        wrdata_r <= {bus.RXDATA, word_buf_r};
      end
      if (data_byte_s && !word_full_s) begin
        word_buf_r <= {bus.RXDATA, word_buf_r[23:8]};
      end
      if (sync_s) begin
        byte_cnt_r <= 2'd0;
      end else if (data_byte_s) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
      end
      if (sync_s) begin
        wraddr_r <= BASE_ADDR;
      end else if (write_r) begin
        wraddr_r <= wraddr_r + 16'd4;
      end
    end
  end

  // Frame length capture and remaining-word counter.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      len_h_r    <= 8'd0;
      word_cnt_r <= 16'd0;
    end else begin
      if (lenh_s) begin
        len_h_r <= bus.RXDATA;
      end
      if (len_load_s) begin
        word_cnt_r <= len_s;
      end else if (write_r) begin
        word_cnt_r <= word_cnt_r - 16'd1;
      end
    end
  end

  // Inter-byte idle counter, only counting while a frame is in progress.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tmo_cnt_r <= 24'd0;
    end else if (active_s && !bus.RX_FLAG_P) begin
      tmo_cnt_r <= tmo_cnt_r + 24'd1;
    end else begin
      tmo_cnt_r <= 24'd0;
    end
  end

`ifdef ISP_CSUM_EN
  // Running checksum over the data bytes of the current frame.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      csum_r <= 8'd0;
    end else if (sync_s) begin
      csum_r <= 8'd0;
    end else if (data_byte_s) begin
      csum_r <= csum_add(csum_r, bus.RXDATA);
    end
  end
`endif

  // Status flags: BUSY follows the FSM, DONE/ERR are sticky until the next sync.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      core_resetn_r <= 1'b0;
    end else begin
      busy_r        <= busy_nx_s;
      core_resetn_r <= !(bus.EN || busy_r);
      if (sync_s) begin
        done_r <= 1'b0;
        err_r  <= 1'b0;
      end else begin
        if (fin_ok_s) begin
          done_r <= 1'b1;
        end
        if (fin_err_s) begin
          err_r <= 1'b1;
        end
      end
    end
  end

  assign bus.CORE_RESETn = core_resetn_r;
  assign bus.WRITE       = write_r;
  assign bus.WRADDR      = wraddr_r;
  assign bus.WRDATA      = wrdata_r;
  assign bus.BUSY        = busy_r;
  assign bus.DONE        = done_r;
  assign bus.ERR         = err_r;

endmodule

// File: tb/tb_isp_frame_loader.sv
// Scoreboard bench for isp_frame_loader: stimulus pushes expected memory
// writes and frame outcomes into queues, a monitor pops them as the DUT
// produces WRITE strobes and DONE/ERR rising edges.
module tb_isp_frame_loader;

  localparam logic [15:0] BASE = 16'hFFF8;
  localparam int          MAXW = 6;
  localparam logic [23:0] TMO  = 24'd64;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  logic HCLK;
  logic HRESETn;
  isp_frame_loader_if bus();

  isp_frame_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT_CYC(TMO)) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  wr_t        wq[$];
  logic [1:0] rq[$];      // {DONE, ERR} expected at the end of each frame
  logic [7:0] fb[$];      // data bytes of the frame being sent
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares writes and frame outcomes against the queues.
  initial begin
    logic pd, pe;
    wr_t  w;
    logic [1:0] r;
    pd = 1'b0;
    pe = 1'b0;
    forever begin
      @(negedge HCLK);
      if (bus.WRITE === 1'b1) begin
        if (wq.size() == 0) begin
          check("unexpected_write_addr", 32'(bus.WRADDR), 32'hFFFFFFFF);
        end else begin
          w = wq.pop_front();
          check("write_addr", 32'(bus.WRADDR), 32'(w.a));
          check("write_data", bus.WRDATA, w.d);
        end
      end
      if ((bus.DONE && !pd) || (bus.ERR && !pe)) begin
        if (rq.size() == 0) begin
          check("unexpected_outcome", 32'({bus.DONE, bus.ERR}), 32'd0);
        end else begin
          r = rq.pop_front();
          check("frame_outcome", 32'({bus.DONE, bus.ERR}), 32'(r));
        end
      end
      pd = bus.DONE;
      pe = bus.ERR;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.RXDATA    = b;
    bus.RX_FLAG_P = 1'b1;
    @(negedge HCLK);
    bus.RX_FLAG_P = 1'b0;
    repeat ($urandom_range(3, 6)) @(negedge HCLK);
  endtask

  // Reference model: word i = bytes 4i..4i+3 little-endian at BASE+4i (mod 2^16).
  task automatic expect_word(input int i);
    wr_t w;
    w.a = BASE + 16'(4 * i);
    w.d = {fb[4*i+3], fb[4*i+2], fb[4*i+1], fb[4*i]};
    wq.push_back(w);
  endtask

  task automatic run_frame(input int n, input bit good_cs);
    logic [15:0] nn;
    logic [1:0]  res;
    bit          ok_len;
`ifdef ISP_CSUM_EN
    logic [7:0]  sum;
`endif
    nn     = 16'(n);
    ok_len = (n >= 1) && (n <= MAXW);
    if (ok_len) begin
      for (int i = 0; i < n; i++) expect_word(i);
      res = good_cs ? 2'b10 : 2'b01;
`ifndef ISP_CSUM_EN
      res = 2'b10;
`endif
    end else begin
      res = 2'b01;
    end
    rq.push_back(res);
    send_byte(8'hA5);
    send_byte(nn[15:8]);
    send_byte(nn[7:0]);
    if (ok_len) begin
      for (int i = 0; i < 4 * n; i++) send_byte(fb[i]);
`ifdef ISP_CSUM_EN
      sum = 8'd0;
      for (int i = 0; i < 4 * n; i++) sum = sum + fb[i];
      send_byte(good_cs ? sum : sum + 8'd1);
`endif
    end
    repeat (4) @(negedge HCLK);
  endtask

  task automatic fill_random(input int n);
    fb.delete();
    for (int i = 0; i < 4 * n; i++) fb.push_back(8'($urandom));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_core_resetn"}, 32'(bus.CORE_RESETn), 32'd0);
    check({tag, "_write"},       32'(bus.WRITE),       32'd0);
    check({tag, "_wraddr"},      32'(bus.WRADDR),      32'(BASE));
    check({tag, "_wrdata"},      bus.WRDATA,           32'd0);
    check({tag, "_busy"},        32'(bus.BUSY),        32'd0);
    check({tag, "_done"},        32'(bus.DONE),        32'd0);
    check({tag, "_err"},         32'(bus.ERR),         32'd0);
  endtask

  initial begin
    int n;
    HRESETn       = 1'b0;
    bus.EN        = 1'b0;
    bus.RXDATA    = 8'h00;
    bus.RX_FLAG_P = 1'b0;
    repeat (3) @(negedge HCLK);
    check_reset_vals("reset");
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("core_release_after_reset", 32'(bus.CORE_RESETn), 32'd1);

    // Bytes with EN low, including a sync byte, are ignored.
    send_byte(8'hA5);
    send_byte(8'h00);
    check("en_low_ignored_busy", 32'(bus.BUSY), 32'd0);

    bus.EN = 1'b1;
    repeat (2) @(negedge HCLK);
    check("core_held_with_en", 32'(bus.CORE_RESETn), 32'd0);

    // Noise before the sync byte, then the reference two-word frame.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("noise_ignored_busy", 32'(bus.BUSY), 32'd0);
    fb = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_frame(2, 1'b1);
    check("ref_frame_done", 32'(bus.DONE), 32'd1);
    check("ref_frame_err",  32'(bus.ERR),  32'd0);
`ifdef ISP_CSUM_EN
    run_frame(2, 1'b0);
    check("bad_csum_err",  32'(bus.ERR),  32'd1);
    check("bad_csum_done", 32'(bus.DONE), 32'd0);
`endif

    // Length boundaries.
    run_frame(0, 1'b1);
    run_frame(MAXW + 1, 1'b1);
    fill_random(MAXW);
    run_frame(MAXW, 1'b1);
    check("max_len_done", 32'(bus.DONE), 32'd1);

    // Mid-frame timeout, then recovery.
    rq.push_back(2'b01);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (int'(TMO) + 20) @(negedge HCLK);
    check("timeout_busy", 32'(bus.BUSY), 32'd0);
    check("timeout_err",  32'(bus.ERR),  32'd1);
    fill_random(1);
    run_frame(1, 1'b1);

    // EN falls during DATA after one complete word.
    fill_random(2);
    expect_word(0);
    rq.push_back(2'b01);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    for (int i = 0; i < 6; i++) send_byte(fb[i]);
    bus.EN = 1'b0;
    @(negedge HCLK);
    check("en_fall_err",         32'(bus.ERR),         32'd1);
    check("en_fall_busy",        32'(bus.BUSY),        32'd0);
    check("en_fall_core_held",   32'(bus.CORE_RESETn), 32'd0);
    @(negedge HCLK);
    check("en_fall_core_release", 32'(bus.CORE_RESETn), 32'd1);
    bus.EN = 1'b1;
    repeat (3) @(negedge HCLK);

    // Randomized frames, occasionally with bad length or checksum.
    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(0, MAXW + 1);
      fill_random((n >= 1 && n <= MAXW) ? n : 0);
      run_frame(n, ($urandom_range(0, 3) != 0));
    end

    // Reset pulse in the middle of a frame.
    fill_random(3);
    expect_word(0);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h03);
    for (int i = 0; i < 6; i++) send_byte(fb[i]);
    HRESETn = 1'b0;
    #1;
    check_reset_vals("midframe_reset");
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
    fill_random(3);
    run_frame(3, 1'b1);

    repeat (20) @(negedge HCLK);
    check("pending_writes",   32'(wq.size()), 32'd0);
    check("pending_outcomes", 32'(rq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
